// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and defaults for the SPI frame receiver
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        COMMIT,
        ABORT
    } spi_state_t;

    localparam int DEFAULT_FRAME_BITS = 432;

endpackage

// File: rtl/sync_edge_detect.sv
// rtl/sync_edge_detect.sv - multi-flop synchroniser with rise/fall detection
module sync_edge_detect #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              dly_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            dly_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
            dly_q  <= sync_q[STAGES-1];
        end
    end

    assign q    = sync_q[STAGES-1];
    assign rise = q & ~dly_q;
    assign fall = ~q & dly_q;

endmodule

// File: rtl/spi_frame_rx.sv
// rtl/spi_frame_rx.sv - oversampled CPOL0/CPHA0 SPI slave with atomic frame commit
module spi_frame_rx
    import spi_pkg::*;
#(
    parameter int FRAME_BITS  = DEFAULT_FRAME_BITS,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sck,
    input  logic                  sdi,
    input  logic                  load,
    output logic                  sdo,
    input  logic [FRAME_BITS-1:0] tx_data,
    output logic [FRAME_BITS-1:0] frame_out,
    output logic                  frame_valid,
    output logic                  frame_err,
    output logic                  busy
);

    localparam int               CNT_W    = $clog2(FRAME_BITS + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0] CNT_OVER = CNT_W'(FRAME_BITS + 1);

    logic sck_rise, sck_fall, load_rise, load_fall, sdi_s;
    logic sck_unused_q, load_unused_q, sdi_unused_rise, sdi_unused_fall;

    sync_edge_detect #(.STAGES(SYNC_STAGES)) u_sck_sync (
        .clk(clk), .rst_n(rst_n), .d(sck),
        .q(sck_unused_q), .rise(sck_rise), .fall(sck_fall)
    );

    sync_edge_detect #(.STAGES(SYNC_STAGES)) u_load_sync (
        .clk(clk), .rst_n(rst_n), .d(load),
        .q(load_unused_q), .rise(load_rise), .fall(load_fall)
    );

    sync_edge_detect #(.STAGES(SYNC_STAGES)) u_sdi_sync (
        .clk(clk), .rst_n(rst_n), .d(sdi),
        .q(sdi_s), .rise(sdi_unused_rise), .fall(sdi_unused_fall)
    );

    spi_state_t            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [FRAME_BITS-1:0] rx_sr_q, rx_sr_d;
    logic [FRAME_BITS-1:0] tx_sr_q, tx_sr_d;
    logic [FRAME_BITS-1:0] frame_q, frame_d;
    logic                  sdo_q, sdo_d;
    logic                  valid_q, valid_d;
    logic                  err_q, err_d;
    logic                  start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rx_sr_q <= '0;
            tx_sr_q <= '0;
            frame_q <= '0;
            sdo_q   <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rx_sr_q <= rx_sr_d;
            tx_sr_q <= tx_sr_d;
            frame_q <= frame_d;
            sdo_q   <= sdo_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rx_sr_d = rx_sr_q;
        tx_sr_d = tx_sr_q;
        frame_d = frame_q;
        sdo_d   = sdo_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        start   = 1'b0;

        case (state_q)
            IDLE: start = load_rise;
            SHIFT: begin
                // The load fall wins over any sck edge seen in the same clk.
                if (load_fall) begin
                    state_d = (cnt_q == CNT_FULL) ? COMMIT : ABORT;
                end else begin
                    if (sck_rise) begin
                        rx_sr_d = {rx_sr_q[FRAME_BITS-2:0], sdi_s};
                        if (cnt_q != CNT_OVER) cnt_d = cnt_q + CNT_W'(1);
                    end
                    if (sck_fall) begin
                        tx_sr_d = tx_sr_q << 1;
                        sdo_d   = tx_sr_q[FRAME_BITS-2];
                    end
                end
            end
            COMMIT: begin
                frame_d = rx_sr_q;
                valid_d = 1'b1;
                state_d = IDLE;
                start   = load_rise;
            end
            ABORT: begin
                err_d   = 1'b1;
                state_d = IDLE;
                start   = load_rise;
            end
            default: state_d = IDLE;
        endcase

        if (start) begin
            state_d = SHIFT;
            cnt_d   = '0;
            tx_sr_d = tx_data;
            sdo_d   = tx_data[FRAME_BITS-1];
        end
    end

    assign sdo         = sdo_q;
    assign frame_out   = frame_q;
    assign frame_valid = valid_q;
    assign frame_err   = err_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_spi_frame_rx.sv
// tb/tb_spi_frame_rx.sv - scoreboard bench for spi_frame_rx
module tb_spi_frame_rx;

    localparam int FB = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          sck = 1'b0;
    logic          sdi = 1'b0;
    logic          load = 1'b0;
    logic [FB-1:0] tx_data = '0;
    logic          sdo;
    logic [FB-1:0] frame_out;
    logic          frame_valid, frame_err, busy;

    spi_frame_rx #(.FRAME_BITS(FB), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .sck(sck), .sdi(sdi), .load(load),
        .sdo(sdo), .tx_data(tx_data), .frame_out(frame_out),
        .frame_valid(frame_valid), .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit            is_err;
        logic [FB-1:0] data;
        int            at;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && (frame_valid || frame_err)) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL spurious_pulse actual valid=%b err=%b expected none", frame_valid, frame_err);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("pulse_kind", {62'd0, frame_valid, frame_err}, e.is_err ? 64'd1 : 64'd2);
                chk("frame_out", 64'(frame_out), 64'(e.data));
                chk("pulse_cycle", 64'(cyc), 64'(e.at));
            end
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic run_frame(input logic [31:0] word, input int nbits, input bit good,
                             input logic [FB-1:0] exp_out, input int gap,
                             output logic [FB-1:0] rb);
        load = 1'b1;
        wait_clk(4);
        rb = '0;
        for (int i = nbits - 1; i >= 0; i--) begin
            sdi = word[i];
            wait_clk(4);
            rb  = {rb[FB-2:0], sdo};
            sck = 1'b1;
            wait_clk(4);
            sck = 1'b0;
        end
        wait_clk(4);
        load = 1'b0;
        sb.push_back('{is_err: !good, data: exp_out, at: cyc + 4});
        wait_clk(gap);
    endtask

    logic [FB-1:0] rb;

    initial begin
        wait_clk(3);
        chk("rst_frame_out", 64'(frame_out), 64'h0);
        chk("rst_valid", 64'(frame_valid), 64'h0);
        chk("rst_err", 64'(frame_err), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_sdo", 64'(sdo), 64'h0);
        rst_n = 1'b1;
        wait_clk(3);

        // Readback of tx_data while receiving an arbitrary word
        tx_data = 16'h8001;
        run_frame(32'h5A5A, 16, 1'b1, 16'h5A5A, 10, rb);
        chk("readback_first_bit", 64'(rb[FB-1]), 64'h1);
        chk("readback_word", 64'(rb), 64'h8001);

        tx_data = 16'h0000;
        run_frame(32'hA5C3, 16, 1'b1, 16'hA5C3, 10, rb);

        // Short and long frames are dropped
        run_frame(32'h1234 >> 1, 15, 1'b0, 16'hA5C3, 10, rb);
        run_frame(32'h1_BEEF, 17, 1'b0, 16'hA5C3, 10, rb);

        // Back-to-back with a 3-clk gap
        run_frame(32'h1234, 16, 1'b1, 16'h1234, 3, rb);
        run_frame(32'hFFFF, 16, 1'b1, 16'hFFFF, 10, rb);
        chk("b2b_final", 64'(frame_out), 64'hFFFF);

        // Reset in the middle of a frame
        load = 1'b1;
        wait_clk(4);
        for (int i = 0; i < 8; i++) begin
            sdi = i[0];
            wait_clk(4);
            sck = 1'b1;
            wait_clk(4);
            sck = 1'b0;
        end
        wait_clk(1);
        rst_n = 1'b0;
        #1;
        chk("midrst_frame_out", 64'(frame_out), 64'h0);
        chk("midrst_valid", 64'(frame_valid), 64'h0);
        chk("midrst_err", 64'(frame_err), 64'h0);
        chk("midrst_busy", 64'(busy), 64'h0);
        chk("midrst_sdo", 64'(sdo), 64'h0);
        load = 1'b0;
        sdi  = 1'b0;
        wait_clk(3);
        rst_n = 1'b1;
        wait_clk(3);
        run_frame(32'h00FF, 16, 1'b1, 16'h00FF, 10, rb);

        // sck activity with load low
        repeat (20) begin
            sck = 1'b1;
            wait_clk(4);
            chk("noise_busy", 64'(busy), 64'h0);
            sck = 1'b0;
            wait_clk(4);
        end
        chk("noise_frame_out", 64'(frame_out), 64'h00FF);

        wait_clk(10);
        chk("scoreboard_drained", 64'(sb.size()), 64'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
